// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: dcache request/done bus between the MEM stage (master) and the dcache (slave).
interface mem_access_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  c_req;
    logic [ADDR_W-1:0]     c_addr;
    logic                  c_wr;
    logic [DATA_W/8-1:0]   c_be;
    logic [DATA_W-1:0]     c_wdata;
    logic                  c_done;
    logic [DATA_W-1:0]     c_rdata;
    modport master (output c_req, c_addr, c_wr, c_be, c_wdata, input c_done, c_rdata);
    modport slave  (input c_req, c_addr, c_wr, c_be, c_wdata, output c_done, c_rdata);
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: registered MEM stage driving the dcache over req/done with lane extraction.
// Define MEM_MISALIGN_SPLIT_EN to split misaligned accesses into two aligned beats instead of rejecting them.
module mem_access_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [RA_W-1:0]   wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] memaddr_i,
    input  logic              memwr_i,
    input  logic [1:0]        memcnf_i,
    input  logic              memsigned_i,
    mem_access_unit_if.master dc,
    output logic              wb_valid,
    output logic [RA_W-1:0]   wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              misalign_err,
    output logic              mem_stall
);
    localparam int NB    = DATA_W / 8;
    localparam int BW    = 2 * NB;
    localparam int OFF_W = $clog2(NB);
    localparam int SW    = OFF_W + 3;
`ifdef MEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
    state_t state_q, state_d;

    logic [RA_W-1:0]   wd_q, wd_o_q;
    logic              wreg_q, wr_q, sgn_q, err_q, wreg_o_q, wb_valid_q, merr_q;
    logic [DATA_W-1:0] wdata_q, lo_q, hi_q, wdata_o_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        cnf_q;

    logic              mem_op, nonmem, req, split, sbit;
    logic [OFF_W-1:0]  off;
    logic [1:0]        cnf;
    logic [3:0]        nb;
    logic [BW-1:0]     be_w;
    logic [2*DATA_W-1:0] wd_w;
    logic [DATA_W-1:0] ext, lmask, load_res;

    assign mem_op = state_q == IDLE && ex_valid && memcnf_i != 2'd0;
    assign nonmem = state_q == IDLE && ex_valid && memcnf_i == 2'd0;
    assign req    = state_q == ACC0 || state_q == ACC1;

    // Lane math looks at the live inputs while deciding acceptance, and at the captured copy afterwards.
    assign off   = state_q == IDLE ? memaddr_i[OFF_W-1:0] : addr_q[OFF_W-1:0];
    assign cnf   = state_q == IDLE ? memcnf_i : cnf_q;
    assign nb    = cnf == 2'd1 ? 4'd1 : cnf == 2'd2 ? 4'd2 : 4'd4;
    assign split = SW'(off) + SW'(nb) > SW'(NB);
    assign be_w  = BW'(cnf == 2'd1 ? 4'h1 : cnf == 2'd2 ? 4'h3 : 4'hF) << off;
    assign wd_w  = {{DATA_W{1'b0}}, wdata_q} << {off, 3'b000};

    // Beat 1 sits above beat 0, so one down-shift of the pair assembles split and unsplit loads alike.
    assign ext      = DATA_W'({hi_q, lo_q} >> {off, 3'b000});
    assign lmask    = DATA_W'(cnf == 2'd1 ? 32'hFF : cnf == 2'd2 ? 32'hFFFF : 32'hFFFF_FFFF);
    assign sbit     = sgn_q & (cnf == 2'd1 ? ext[7] : cnf == 2'd2 ? ext[15] : ext[31]);
    assign load_res = (ext & lmask) | (sbit ? ~lmask : '0);

    assign dc.c_req   = req;
    assign dc.c_wr    = req & wr_q;
    assign dc.c_be    = req ? (state_q == ACC1 ? be_w[BW-1:NB] : be_w[NB-1:0]) : '0;
    assign dc.c_wdata = req ? (state_q == ACC1 ? wd_w[2*DATA_W-1:DATA_W] : wd_w[DATA_W-1:0]) : '0;
    assign dc.c_addr  = req ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} +
                              (state_q == ACC1 ? ADDR_W'(NB) : '0) : '0;

    assign mem_stall    = !rst && (state_q != IDLE || mem_op);
    assign wb_valid     = wb_valid_q;
    assign wd_o         = wd_o_q;
    assign wreg_o       = wreg_o_q;
    assign wdata_o      = wdata_o_q;
    assign misalign_err = merr_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (mem_op) state_d = (split && !SPLIT_EN) ? RESP : ACC0;
            ACC0: if (dc.c_done) state_d = (split && SPLIT_EN) ? ACC1 : RESP;
            ACC1: if (dc.c_done) state_d = RESP;
            RESP: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wd_q       <= '0;
            wreg_q     <= 1'b0;
            wr_q       <= 1'b0;
            sgn_q      <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= '0;
            addr_q     <= '0;
            cnf_q      <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            wb_valid_q <= 1'b0;
            wd_o_q     <= '0;
            wreg_o_q   <= 1'b0;
            wdata_o_q  <= '0;
            merr_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (mem_op) begin
                wd_q    <= wd_i;
                wreg_q  <= wreg_i;
                wr_q    <= memwr_i;
                sgn_q   <= memsigned_i;
                wdata_q <= wdata_i;
                addr_q  <= memaddr_i;
                cnf_q   <= memcnf_i;
                err_q   <= split && !SPLIT_EN;
            end
            if (state_q == ACC0 && dc.c_done) lo_q <= dc.c_rdata;
            if (state_q == ACC1 && dc.c_done) hi_q <= dc.c_rdata;
            wb_valid_q <= nonmem || state_q == RESP;
            if (state_q == RESP) begin
                wd_o_q    <= wd_q;
                wreg_o_q  <= wreg_q && !wr_q && !err_q;
                wdata_o_q <= load_res;
                merr_q    <= err_q;
            end else begin
                wreg_o_q <= nonmem && wreg_i;
                merr_q   <= 1'b0;
                if (nonmem) begin
                    wd_o_q    <= wd_i;
                    wdata_o_q <= wdata_i;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit (DATA_W = 32).
// Covers both builds; the misalignment scenario follows MEM_MISALIGN_SPLIT_EN.
module tb_mem_access_unit;
    logic        clk, rst, ex_valid, wreg, memwr, memsigned;
    logic [4:0]  wd;
    logic [31:0] wdata, memaddr;
    logic [1:0]  memcnf;
    logic        wb_valid, wreg_o, misalign_err, mem_stall;
    logic [4:0]  wd_o;
    logic [31:0] wdata_o;
    int checks = 0;
    int errors = 0;

    mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) dc ();

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .RA_W(5)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .wd_i(wd), .wreg_i(wreg), .wdata_i(wdata),
        .memaddr_i(memaddr), .memwr_i(memwr), .memcnf_i(memcnf), .memsigned_i(memsigned),
        .dc(dc), .wb_valid(wb_valid), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .misalign_err(misalign_err), .mem_stall(mem_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; ex_valid = 1'b1; memcnf = 2'd1; memaddr = 32'h40; memwr = 1'b0;
        tick; tick;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset mem_stall: got %b expected 0", mem_stall); end
        checks++; if (dc.c_req !== 1'b0 || dc.c_be !== 4'h0 || dc.c_addr !== 32'h0 || dc.c_wdata !== 32'h0)
            begin errors++; $display("FAIL reset bus: got req %b be %h addr %h wdata %h expected all 0", dc.c_req, dc.c_be, dc.c_addr, dc.c_wdata); end
        checks++; if (wb_valid !== 1'b0 || wreg_o !== 1'b0 || misalign_err !== 1'b0 || wd_o !== 5'd0 || wdata_o !== 32'h0)
            begin errors++; $display("FAIL reset wb: got v %b wreg %b err %b wd %h wdata %h expected all 0", wb_valid, wreg_o, misalign_err, wd_o, wdata_o); end
        ex_valid = 1'b0; memcnf = 2'd0; rst = 1'b0;
        tick;
        checks++; if (wb_valid !== 1'b0 || wreg_o !== 1'b0) begin errors++; $display("FAIL idle_bubble: got v %b wreg %b expected 0 0", wb_valid, wreg_o); end
    endtask

    task automatic test_nonmem;
        ex_valid = 1'b1; memcnf = 2'd0; wd = 5'd5; wreg = 1'b1; wdata = 32'h1234;
        #1;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL nonmem_stall: got %b expected 0", mem_stall); end
        tick;
        checks++; if (wb_valid !== 1'b1 || wd_o !== 5'd5 || wdata_o !== 32'h1234 || wreg_o !== 1'b1 || mem_stall !== 1'b0)
            begin errors++; $display("FAIL nonmem_wb: got v %b wd %0d wdata %h wreg %b stall %b expected 1 5 00001234 1 0", wb_valid, wd_o, wdata_o, wreg_o, mem_stall); end
        ex_valid = 1'b0;
        tick;
        checks++; if (wb_valid !== 1'b0 || wreg_o !== 1'b0) begin errors++; $display("FAIL nonmem_drop: got v %b wreg %b expected 0 0", wb_valid, wreg_o); end
    endtask

    task automatic test_back_to_back;
        ex_valid = 1'b1; memcnf = 2'd0; wd = 5'd1; wreg = 1'b0; wdata = 32'hA;
        tick;
        checks++; if (wb_valid !== 1'b1 || wd_o !== 5'd1 || wreg_o !== 1'b0 || wdata_o !== 32'hA)
            begin errors++; $display("FAIL b2b_first: got v %b wd %0d wreg %b wdata %h expected 1 1 0 0000000a", wb_valid, wd_o, wreg_o, wdata_o); end
        wd = 5'd2; wreg = 1'b1; wdata = 32'hB;
        tick;
        checks++; if (wb_valid !== 1'b1 || wd_o !== 5'd2 || wreg_o !== 1'b1 || wdata_o !== 32'hB)
            begin errors++; $display("FAIL b2b_second: got v %b wd %0d wreg %b wdata %h expected 1 2 1 0000000b", wb_valid, wd_o, wreg_o, wdata_o); end
        ex_valid = 1'b0;
        tick;
    endtask

    task automatic test_load(input string name, input logic [31:0] a, input logic [1:0] cnf, input logic sg,
                             input int waits, input logic [31:0] rd, input logic [31:0] addr_exp,
                             input logic [3:0] be_exp, input logic [31:0] exp);
        ex_valid = 1'b1; memaddr = a; memcnf = cnf; memsigned = sg; memwr = 1'b0; wd = 5'd7; wreg = 1'b1;
        #1;
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL %s accept_stall: got %b expected 1", name, mem_stall); end
        tick;
        checks++; if (dc.c_req !== 1'b1 || dc.c_wr !== 1'b0 || dc.c_addr !== addr_exp || dc.c_be !== be_exp)
            begin errors++; $display("FAIL %s req: got req %b wr %b addr %h be %b expected 1 0 %h %b", name, dc.c_req, dc.c_wr, dc.c_addr, dc.c_be, addr_exp, be_exp); end
        for (int i = 0; i < waits; i++) tick;
        checks++; if (dc.c_req !== 1'b1 || mem_stall !== 1'b1) begin errors++; $display("FAIL %s hold: got req %b stall %b expected 1 1", name, dc.c_req, mem_stall); end
        dc.c_done = 1'b1; dc.c_rdata = rd;
        tick;
        dc.c_done = 1'b0; ex_valid = 1'b0;
        checks++; if (dc.c_req !== 1'b0 || mem_stall !== 1'b1 || wb_valid !== 1'b0)
            begin errors++; $display("FAIL %s resp: got req %b stall %b v %b expected 0 1 0", name, dc.c_req, mem_stall, wb_valid); end
        tick;
        checks++; if (wb_valid !== 1'b1 || wdata_o !== exp || wreg_o !== 1'b1 || wd_o !== 5'd7 || mem_stall !== 1'b0)
            begin errors++; $display("FAIL %s wb: got v %b wdata %h wreg %b wd %0d stall %b expected 1 %h 1 7 0", name, wb_valid, wdata_o, wreg_o, wd_o, mem_stall, exp); end
        tick;
    endtask

    task automatic test_store_half;
        ex_valid = 1'b1; memaddr = 32'h2002; memcnf = 2'd2; memwr = 1'b1; wdata = 32'h0000BEEF; wreg = 1'b1; wd = 5'd3;
        tick;
        checks++; if (dc.c_req !== 1'b1 || dc.c_wr !== 1'b1 || dc.c_addr !== 32'h2000 || dc.c_be !== 4'b1100 || dc.c_wdata !== 32'hBEEF0000)
            begin errors++; $display("FAIL sh_req: got req %b wr %b addr %h be %b wdata %h expected 1 1 00002000 1100 beef0000", dc.c_req, dc.c_wr, dc.c_addr, dc.c_be, dc.c_wdata); end
        dc.c_done = 1'b1;
        tick;
        dc.c_done = 1'b0; ex_valid = 1'b0;
        checks++; if (dc.c_req !== 1'b0) begin errors++; $display("FAIL sh_req_drop: got %b expected 0", dc.c_req); end
        tick;
        checks++; if (wb_valid !== 1'b1 || wreg_o !== 1'b0) begin errors++; $display("FAIL sh_wb: got v %b wreg %b expected 1 0", wb_valid, wreg_o); end
        memwr = 1'b0;
        tick;
    endtask

`ifdef MEM_MISALIGN_SPLIT_EN
    task automatic test_misalign;
        ex_valid = 1'b1; memaddr = 32'h3002; memcnf = 2'd3; memwr = 1'b0; memsigned = 1'b0; wreg = 1'b1; wd = 5'd9;
        tick;
        checks++; if (dc.c_req !== 1'b1 || dc.c_addr !== 32'h3000 || dc.c_be !== 4'b1100)
            begin errors++; $display("FAIL split_beat0: got req %b addr %h be %b expected 1 00003000 1100", dc.c_req, dc.c_addr, dc.c_be); end
        dc.c_done = 1'b1; dc.c_rdata = 32'h2211AAAA;
        tick;
        checks++; if (dc.c_req !== 1'b1 || dc.c_addr !== 32'h3004 || dc.c_be !== 4'b0011)
            begin errors++; $display("FAIL split_beat1: got req %b addr %h be %b expected 1 00003004 0011", dc.c_req, dc.c_addr, dc.c_be); end
        dc.c_rdata = 32'hBBBB4433;
        tick;
        dc.c_done = 1'b0; ex_valid = 1'b0;
        tick;
        checks++; if (wb_valid !== 1'b1 || wdata_o !== 32'h44332211 || wreg_o !== 1'b1 || misalign_err !== 1'b0)
            begin errors++; $display("FAIL split_wb: got v %b wdata %h wreg %b err %b expected 1 44332211 1 0", wb_valid, wdata_o, wreg_o, misalign_err); end
        tick;
    endtask
`else
    task automatic test_misalign;
        ex_valid = 1'b1; memaddr = 32'h3003; memcnf = 2'd2; memwr = 1'b0; wreg = 1'b1; wd = 5'd9;
        #1;
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL mis_stall: got %b expected 1", mem_stall); end
        tick;
        ex_valid = 1'b0;
        checks++; if (dc.c_req !== 1'b0 || misalign_err !== 1'b0 || mem_stall !== 1'b1)
            begin errors++; $display("FAIL mis_resp: got req %b err %b stall %b expected 0 0 1", dc.c_req, misalign_err, mem_stall); end
        tick;
        checks++; if (misalign_err !== 1'b1 || wb_valid !== 1'b1 || wreg_o !== 1'b0 || dc.c_req !== 1'b0)
            begin errors++; $display("FAIL mis_pulse: got err %b v %b wreg %b req %b expected 1 1 0 0", misalign_err, wb_valid, wreg_o, dc.c_req); end
        tick;
        checks++; if (misalign_err !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL mis_once: got err %b v %b expected 0 0", misalign_err, wb_valid); end
    endtask
`endif

    task automatic test_reset_mid;
        ex_valid = 1'b1; memaddr = 32'h1000; memcnf = 2'd1; memwr = 1'b0; wreg = 1'b1;
        tick;
        checks++; if (dc.c_req !== 1'b1) begin errors++; $display("FAIL rmid_req: got %b expected 1", dc.c_req); end
        rst = 1'b1;
        tick;
        checks++; if (dc.c_req !== 1'b0) begin errors++; $display("FAIL rmid_drop: got %b expected 0", dc.c_req); end
        rst = 1'b0; ex_valid = 1'b0; dc.c_done = 1'b1; dc.c_rdata = 32'hFFFFFFFF;
        tick;
        dc.c_done = 1'b0;
        checks++; if (dc.c_req !== 1'b0 || wb_valid !== 1'b0 || mem_stall !== 1'b0)
            begin errors++; $display("FAIL rmid_done: got req %b v %b stall %b expected 0 0 0", dc.c_req, wb_valid, mem_stall); end
        tick;
        checks++; if (wb_valid !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL rmid_idle: got v %b stall %b expected 0 0", wb_valid, mem_stall); end
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; wd = '0; wreg = 1'b0; wdata = '0; memaddr = '0;
        memwr = 1'b0; memcnf = '0; memsigned = 1'b0; dc.c_done = 1'b0; dc.c_rdata = '0;
        test_reset;
        test_nonmem;
        test_back_to_back;
        test_load("lb_signed", 32'h1003, 2'd1, 1'b1, 3, 32'h80AABBCC, 32'h1000, 4'b1000, 32'hFFFFFF80);
        test_load("lbu_off1", 32'h1001, 2'd1, 1'b0, 0, 32'h1234F678, 32'h1000, 4'b0010, 32'h000000F6);
        test_load("lh_signed", 32'h2006, 2'd2, 1'b1, 1, 32'h8001CAFE, 32'h2004, 4'b1100, 32'hFFFF8001);
        test_load("lw_aligned", 32'h2008, 2'd3, 1'b1, 0, 32'h89ABCDEF, 32'h2008, 4'b1111, 32'h89ABCDEF);
        test_store_half;
        test_misalign;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
